// File: rtl/alu_port_arbiter.sv
// alu_port_arbiter: shares the execute-stage ALU operand port between the
// ID/EX pipeline and an auxiliary multi-cycle unit. Grants are combinational,
// operands are registered into the ALU issue slot, and a starvation counter
// forces aux ahead of pipe after MAX_WAIT consecutive denied cycles.
module alu_port_arbiter #(
   parameter int unsigned SIMD_W   = 128,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned MAX_WAIT = 4,
   parameter int unsigned LEN_W    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pipe_req,
   input  logic              pipe_sel1,
   input  logic              pipe_sel2,
   input  logic [SIMD_W-1:0] pipe_rs1,
   input  logic [SIMD_W-1:0] pipe_rs2,
   input  logic [ADDR_W-1:0] pipe_pc,
   input  logic [DATA_W-1:0] pipe_imm,
   output logic              pipe_gnt,
   output logic              pipe_stall,
   input  logic              aux_req,
   input  logic [LEN_W-1:0]  aux_len,
   input  logic [SIMD_W-1:0] aux_a,
   input  logic [SIMD_W-1:0] aux_b,
   output logic              aux_gnt,
   output logic [SIMD_W-1:0] alu_s1,
   output logic [SIMD_W-1:0] alu_s2,
   output logic              alu_valid,
   output logic              alu_owner
);

   typedef enum logic {
      ST_ARB,
      ST_BURST
   } state_t;

   localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

   state_t              state_q, state_d;
   logic [3:0]          wait_q, wait_d;
   logic [LEN_W-1:0]    rem_q, rem_d;
   logic [SIMD_W-1:0]   s1_q, s2_q;
   logic                valid_q, owner_q;

   logic [LEN_W-1:0]    eff_len;
   logic [SIMD_W-1:0]   pipe_s1, pipe_s2;

   // A zero burst length is treated as a single beat.
   assign eff_len = (aux_len == '0) ? LEN_W'(1) : aux_len;

   // Pipe operands are zero-extended when PC/imm are selected.
   assign pipe_s1 = pipe_sel1 ? pipe_rs1 : SIMD_W'(pipe_pc);
   assign pipe_s2 = pipe_sel2 ? pipe_rs2 : SIMD_W'(pipe_imm);

   // Arbitration, burst tracking and starvation counter next-state.
   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      wait_d   = '0;
      pipe_gnt = 1'b0;
      aux_gnt  = 1'b0;

      if (!rst) begin
         if (state_q == ST_BURST && aux_req) begin
            aux_gnt = 1'b1;
            rem_d   = rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
               state_d = ST_ARB;
            end
         end else begin
            // Normal arbitration; also covers an aborted burst, which
            // re-arbitrates in the same cycle so pipe is not penalised.
            state_d = ST_ARB;
            rem_d   = '0;
            if (pipe_req && (!aux_req || wait_q < MAX_WAIT_C)) begin
               pipe_gnt = 1'b1;
            end else if (aux_req) begin
               aux_gnt = 1'b1;
               if (eff_len > LEN_W'(1)) begin
                  rem_d   = eff_len - LEN_W'(1);
                  state_d = ST_BURST;
               end
            end
         end

         if (aux_req && !aux_gnt) begin
            wait_d = (wait_q == MAX_WAIT_C) ? wait_q : wait_q + 4'd1;
         end
      end
   end

   assign pipe_stall = pipe_req & ~pipe_gnt;

   // State, counters and the ALU issue slot registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_ARB;
         wait_q  <= '0;
         rem_q   <= '0;
         s1_q    <= '0;
         s2_q    <= '0;
         valid_q <= 1'b0;
         owner_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         rem_q   <= rem_d;
         valid_q <= pipe_gnt | aux_gnt;
         if (pipe_gnt) begin
            s1_q    <= pipe_s1;
            s2_q    <= pipe_s2;
            owner_q <= 1'b0;
         end else if (aux_gnt) begin
            s1_q    <= aux_a;
            s2_q    <= aux_b;
            owner_q <= 1'b1;
         end
      end
   end

   assign alu_s1    = s1_q;
   assign alu_s2    = s2_q;
   assign alu_valid = valid_q;
   assign alu_owner = owner_q;

endmodule

// File: tb/tb_alu_port_arbiter.sv
// Self-checking bench for alu_port_arbiter: directed scenarios plus a
// randomized run compared against an integer-level behavioural model.
module tb_alu_port_arbiter;

   localparam int MAXW = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         pipe_req, pipe_sel1, pipe_sel2;
   logic [127:0] pipe_rs1, pipe_rs2;
   logic [31:0]  pipe_pc, pipe_imm;
   logic         pipe_gnt, pipe_stall;
   logic         aux_req;
   logic [3:0]   aux_len;
   logic [127:0] aux_a, aux_b;
   logic         aux_gnt;
   logic [127:0] alu_s1, alu_s2;
   logic         alu_valid, alu_owner;

   int n_cmp = 0;
   int n_err = 0;

   // Behavioural model state
   int           m_wait = 0;
   int           m_left = 0;
   logic [127:0] m_s1 = '0, m_s2 = '0;
   logic         m_valid = 1'b0, m_owner = 1'b0;

   always #5 clk = ~clk;

   alu_port_arbiter #(
      .SIMD_W(128), .DATA_W(32), .ADDR_W(32), .MAX_WAIT(MAXW), .LEN_W(4)
   ) dut (
      .clk(clk), .rst(rst),
      .pipe_req(pipe_req), .pipe_sel1(pipe_sel1), .pipe_sel2(pipe_sel2),
      .pipe_rs1(pipe_rs1), .pipe_rs2(pipe_rs2), .pipe_pc(pipe_pc),
      .pipe_imm(pipe_imm), .pipe_gnt(pipe_gnt), .pipe_stall(pipe_stall),
      .aux_req(aux_req), .aux_len(aux_len), .aux_a(aux_a), .aux_b(aux_b),
      .aux_gnt(aux_gnt), .alu_s1(alu_s1), .alu_s2(alu_s2),
      .alu_valid(alu_valid), .alu_owner(alu_owner)
   );

   // Who gets the port this cycle, from the arbitration rules.
   function automatic void model_grant(output logic pg, output logic ag);
      pg = 1'b0;
      ag = 1'b0;
      if (!rst) begin
         if (m_left > 0 && aux_req) ag = 1'b1;
         else begin
            pg = pipe_req && (!aux_req || m_wait < MAXW);
            ag = !pg && aux_req;
         end
      end
   endfunction

   task automatic randomize_data();
      pipe_sel1 = 1'($urandom);
      pipe_sel2 = 1'($urandom);
      pipe_rs1  = {$urandom, $urandom, $urandom, $urandom};
      pipe_rs2  = {$urandom, $urandom, $urandom, $urandom};
      pipe_pc   = $urandom;
      pipe_imm  = $urandom;
      aux_a     = {$urandom, $urandom, $urandom, $urandom};
      aux_b     = {$urandom, $urandom, $urandom, $urandom};
   endtask

   // Advance one clock, updating the model with the inputs of that cycle.
   task automatic tick();
      logic pg, ag;
      int   len;
      model_grant(pg, ag);
      @(posedge clk);
      if (rst) begin
         m_wait = 0; m_left = 0; m_s1 = '0; m_s2 = '0;
         m_valid = 1'b0; m_owner = 1'b0;
      end else begin
         if (pg) begin
            m_s1 = '0; m_s2 = '0;
            if (pipe_sel1) m_s1 = pipe_rs1; else m_s1[31:0] = pipe_pc;
            if (pipe_sel2) m_s2 = pipe_rs2; else m_s2[31:0] = pipe_imm;
            m_owner = 1'b0;
         end else if (ag) begin
            m_s1 = aux_a; m_s2 = aux_b; m_owner = 1'b1;
         end
         m_valid = pg | ag;
         len = (aux_len == 0) ? 1 : int'(aux_len);
         if (m_left > 0 && aux_req) m_left = m_left - 1;
         else if (ag) m_left = len - 1;
         else m_left = 0;
         if (aux_req && !ag) m_wait = (m_wait + 1 > MAXW) ? MAXW : m_wait + 1;
         else m_wait = 0;
      end
      #1;
   endtask

   task automatic go_idle();
      pipe_req = 1'b0; aux_req = 1'b0;
      #3; tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; pipe_req = 1'b1; aux_req = 1'b1; aux_len = 4'd4;
      for (int i = 0; i < 3; i++) begin
         randomize_data();
         #3;
         n_cmp++; if (pipe_gnt !== 1'b0) begin n_err++; $display("FAIL rst_pipe_gnt got=%0b exp=0", pipe_gnt); end
         n_cmp++; if (aux_gnt !== 1'b0) begin n_err++; $display("FAIL rst_aux_gnt got=%0b exp=0", aux_gnt); end
         tick();
      end
      rst = 1'b0; pipe_req = 1'b0; aux_req = 1'b0;
      #3; tick();
      n_cmp++; if (alu_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%0b exp=0", alu_valid); end
      n_cmp++; if (alu_s1 !== 128'h0) begin n_err++; $display("FAIL rst_s1 got=%h exp=0", alu_s1); end
   endtask

   task automatic test_pipe_operands();
      logic [127:0] e1, e2;
      randomize_data();
      pipe_req = 1'b1; aux_req = 1'b0;
      pipe_sel1 = 1'b0; pipe_pc = 32'h8000_0010;
      pipe_sel2 = 1'b0; pipe_imm = 32'hFFFF_FFFC;
      #3;
      n_cmp++; if (pipe_gnt !== 1'b1) begin n_err++; $display("FAIL op_pipe_gnt got=%0b exp=1", pipe_gnt); end
      n_cmp++; if (pipe_stall !== 1'b0) begin n_err++; $display("FAIL op_stall got=%0b exp=0", pipe_stall); end
      tick();
      n_cmp++; if (alu_s1 !== 128'h8000_0010) begin n_err++; $display("FAIL op_s1_pc got=%h exp=%h", alu_s1, 128'h8000_0010); end
      n_cmp++; if (alu_s2 !== 128'hFFFF_FFFC) begin n_err++; $display("FAIL op_s2_imm got=%h exp=%h", alu_s2, 128'hFFFF_FFFC); end
      n_cmp++; if ({alu_valid, alu_owner} !== 2'b10) begin n_err++; $display("FAIL op_valid_owner got=%b exp=10", {alu_valid, alu_owner}); end
      randomize_data();
      pipe_sel1 = 1'b1; pipe_sel2 = 1'b1;
      e1 = pipe_rs1; e2 = pipe_rs2;
      #3; tick();
      n_cmp++; if (alu_s1 !== e1) begin n_err++; $display("FAIL op_s1_rs got=%h exp=%h", alu_s1, e1); end
      n_cmp++; if (alu_s2 !== e2) begin n_err++; $display("FAIL op_s2_rs got=%h exp=%h", alu_s2, e2); end
      pipe_req = 1'b0; randomize_data();
      #3;
      n_cmp++; if ({pipe_gnt, pipe_stall} !== 2'b00) begin n_err++; $display("FAIL op_idle_gnt got=%b exp=00", {pipe_gnt, pipe_stall}); end
      tick();
      n_cmp++; if (alu_valid !== 1'b0) begin n_err++; $display("FAIL op_idle_valid got=%0b exp=0", alu_valid); end
      n_cmp++; if (alu_s1 !== e1) begin n_err++; $display("FAIL op_hold_s1 got=%h exp=%h", alu_s1, e1); end
   endtask

   task automatic test_fairness();
      logic epg;
      pipe_req = 1'b1; aux_req = 1'b1; aux_len = 4'd1;
      for (int i = 0; i < 15; i++) begin
         randomize_data();
         epg = ((i % 5) != 4);
         #3;
         n_cmp++; if (pipe_gnt !== epg) begin n_err++; $display("FAIL fair_pipe_gnt c%0d got=%0b exp=%0b", i, pipe_gnt, epg); end
         n_cmp++; if (aux_gnt !== !epg) begin n_err++; $display("FAIL fair_aux_gnt c%0d got=%0b exp=%0b", i, aux_gnt, !epg); end
         n_cmp++; if (pipe_stall !== !epg) begin n_err++; $display("FAIL fair_stall c%0d got=%0b exp=%0b", i, pipe_stall, !epg); end
         tick();
         n_cmp++; if (alu_owner !== !epg) begin n_err++; $display("FAIL fair_owner c%0d got=%0b exp=%0b", i, alu_owner, !epg); end
      end
      go_idle();
   endtask

   task automatic test_burst();
      logic eag;
      logic [127:0] ea;
      pipe_req = 1'b1; aux_req = 1'b1; aux_len = 4'd3;
      for (int i = 0; i < 8; i++) begin
         randomize_data();
         if (i > 4) aux_len = 4'd7;
         eag = (i >= 4 && i <= 6);
         ea = aux_a;
         #3;
         n_cmp++; if (aux_gnt !== eag) begin n_err++; $display("FAIL burst_aux_gnt c%0d got=%0b exp=%0b", i, aux_gnt, eag); end
         n_cmp++; if (pipe_gnt !== !eag) begin n_err++; $display("FAIL burst_pipe_gnt c%0d got=%0b exp=%0b", i, pipe_gnt, !eag); end
         n_cmp++; if (pipe_stall !== eag) begin n_err++; $display("FAIL burst_stall c%0d got=%0b exp=%0b", i, pipe_stall, eag); end
         tick();
         n_cmp++; if (alu_owner !== eag) begin n_err++; $display("FAIL burst_owner c%0d got=%0b exp=%0b", i, alu_owner, eag); end
         if (eag) begin
            n_cmp++; if (alu_s1 !== ea) begin n_err++; $display("FAIL burst_s1 c%0d got=%h exp=%h", i, alu_s1, ea); end
         end
      end
      go_idle();
   endtask

   task automatic test_abort();
      randomize_data();
      pipe_req = 1'b0; aux_req = 1'b1; aux_len = 4'd3;
      #3;
      n_cmp++; if (aux_gnt !== 1'b1) begin n_err++; $display("FAIL abort_beat1 got=%0b exp=1", aux_gnt); end
      tick();
      aux_req = 1'b0; pipe_req = 1'b1;
      #3;
      n_cmp++; if (pipe_gnt !== 1'b1) begin n_err++; $display("FAIL abort_pipe_gnt got=%0b exp=1", pipe_gnt); end
      n_cmp++; if (aux_gnt !== 1'b0) begin n_err++; $display("FAIL abort_aux_gnt got=%0b exp=0", aux_gnt); end
      tick();
      n_cmp++; if (alu_owner !== 1'b0) begin n_err++; $display("FAIL abort_owner got=%0b exp=0", alu_owner); end
      pipe_req = 1'b0; aux_req = 1'b1; aux_len = 4'd0;
      #3;
      n_cmp++; if (aux_gnt !== 1'b1) begin n_err++; $display("FAIL len0_beat got=%0b exp=1", aux_gnt); end
      tick();
      pipe_req = 1'b1;
      #3;
      n_cmp++; if (pipe_gnt !== 1'b1) begin n_err++; $display("FAIL len0_single got=%0b exp=1", pipe_gnt); end
      tick();
      go_idle();
   endtask

   task automatic test_reset_mid_burst();
      randomize_data();
      pipe_req = 1'b0; aux_req = 1'b1; aux_len = 4'd4;
      #3;
      n_cmp++; if (aux_gnt !== 1'b1) begin n_err++; $display("FAIL rmb_beat1 got=%0b exp=1", aux_gnt); end
      tick();
      rst = 1'b1; pipe_req = 1'b1;
      #3;
      n_cmp++; if ({pipe_gnt, aux_gnt} !== 2'b00) begin n_err++; $display("FAIL rmb_gnt got=%b exp=00", {pipe_gnt, aux_gnt}); end
      tick();
      n_cmp++; if ({alu_valid, alu_owner} !== 2'b00) begin n_err++; $display("FAIL rmb_valid_owner got=%b exp=00", {alu_valid, alu_owner}); end
      n_cmp++; if ({alu_s1, alu_s2} !== 256'h0) begin n_err++; $display("FAIL rmb_operands got=%h exp=0", {alu_s1, alu_s2}); end
      rst = 1'b0;
      #3;
      n_cmp++; if ({pipe_gnt, aux_gnt} !== 2'b10) begin n_err++; $display("FAIL rmb_release got=%b exp=10", {pipe_gnt, aux_gnt}); end
      tick();
      go_idle();
   endtask

   task automatic test_random();
      logic pg, ag;
      for (int i = 0; i < 400; i++) begin
         rst      = ($urandom_range(0, 59) == 0);
         pipe_req = ($urandom_range(0, 3) != 0);
         aux_req  = ($urandom_range(0, 3) != 0);
         aux_len  = 4'($urandom);
         randomize_data();
         #3;
         model_grant(pg, ag);
         n_cmp++; if (pipe_gnt !== pg) begin n_err++; $display("FAIL rnd_pipe_gnt c%0d got=%0b exp=%0b", i, pipe_gnt, pg); end
         n_cmp++; if (aux_gnt !== ag) begin n_err++; $display("FAIL rnd_aux_gnt c%0d got=%0b exp=%0b", i, aux_gnt, ag); end
         n_cmp++; if (pipe_stall !== (pipe_req & ~pg)) begin n_err++; $display("FAIL rnd_stall c%0d got=%0b exp=%0b", i, pipe_stall, pipe_req & ~pg); end
         n_cmp++; if ((pipe_gnt & aux_gnt) !== 1'b0) begin n_err++; $display("FAIL rnd_dual_gnt c%0d got=1 exp=0", i); end
         tick();
         n_cmp++; if ({alu_valid, alu_owner} !== {m_valid, m_owner}) begin n_err++; $display("FAIL rnd_valid_owner c%0d got=%b exp=%b", i, {alu_valid, alu_owner}, {m_valid, m_owner}); end
         n_cmp++; if (alu_s1 !== m_s1) begin n_err++; $display("FAIL rnd_s1 c%0d got=%h exp=%h", i, alu_s1, m_s1); end
         n_cmp++; if (alu_s2 !== m_s2) begin n_err++; $display("FAIL rnd_s2 c%0d got=%h exp=%h", i, alu_s2, m_s2); end
      end
      rst = 1'b0;
      go_idle();
   endtask

   initial begin
      rst = 1'b1; pipe_req = 1'b0; aux_req = 1'b0; aux_len = '0;
      randomize_data();
      @(posedge clk); #1;
      test_reset();
      test_pipe_operands();
      test_fairness();
      test_burst();
      test_abort();
      test_reset_mid_burst();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
